// File: rtl/binary_downscale_2x2.sv
// 2x2 binary-image decimator: one thresholded output pixel per non-overlapping 2x2 block.
// Optional RESIZE_CNT_OUT_EN adds dout_cnt, the raw ones count of each emitted block.
module binary_downscale_2x2 #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned THRESH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic       din,
  input  logic       din_sof,
  input  logic [2:0] cfg_thresh,
  output logic       dout_valid,
  output logic       dout,
  output logic       dout_sof,
  output logic       dout_eol,
`ifdef RESIZE_CNT_OUT_EN
  output logic [2:0] dout_cnt,
`endif
  output logic       frame_done
);

  if ((IMG_W < 2) || (IMG_W % 2 != 0)) begin : gen_bad_width
    $error("IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || (IMG_H % 2 != 0)) begin : gen_bad_height
    $error("IMG_H must be even and >= 2");
  end
  if (THRESH > 7) begin : gen_bad_thresh
    $error("THRESH must be in 0..7");
  end

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColOne  = CW'(1);
  localparam logic [RW-1:0] RowOne  = RW'(1);

  logic [CW-1:0]  col_q, col_d, cur_col;
  logic [RW-1:0]  row_q, row_d, cur_row;
  logic [IMG_W:0] line_q;
  logic [2:0]     thr_q;
  logic [2:0]     cnt;
  logic           emit, col_last, row_last;

  // line_q[0] is the left neighbour, [IMG_W-1] the pixel above, [IMG_W] the one above-left.
  always_comb begin
    cur_col  = din_sof ? '0 : col_q;
    cur_row  = din_sof ? '0 : row_q;
    col_last = (cur_col == ColLast);
    row_last = (cur_row == RowLast);
    emit     = din_valid && cur_col[0] && cur_row[0];
    cnt      = {2'b00, line_q[IMG_W]} + {2'b00, line_q[IMG_W-1]}
             + {2'b00, line_q[0]} + {2'b00, din};
    col_d    = col_last ? '0 : cur_col + ColOne;
    row_d    = cur_row;
    if (col_last) begin
      row_d = row_last ? '0 : cur_row + RowOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      line_q     <= '0;
      thr_q      <= 3'(THRESH);
      dout_valid <= 1'b0;
      dout       <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eol   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= emit;
      dout       <= emit && (cnt >= thr_q);
      dout_sof   <= emit && (cur_row == RowOne) && (cur_col == ColOne);
      dout_eol   <= emit && col_last;
      frame_done <= emit && col_last && row_last;
      if (din_valid) begin
        col_q  <= col_d;
        row_q  <= row_d;
        line_q <= {line_q[IMG_W-1:0], din};
        if (din_sof) begin
          thr_q <= cfg_thresh;
        end
      end
    end
  end

`ifdef RESIZE_CNT_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_cnt <= 3'd0;
    end else begin
      dout_cnt <= emit ? cnt : 3'd0;
    end
  end
`endif

endmodule

// File: tb/tb_binary_downscale_2x2.sv
// Randomised self-checking bench for binary_downscale_2x2 against a frame-array reference model.
module tb_binary_downscale_2x2;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk, rst_n, din_valid, din, din_sof;
  logic [2:0] cfg_thresh;
  logic       dout_valid, dout, dout_sof, dout_eol, frame_done;
`ifdef RESIZE_CNT_OUT_EN
  logic [2:0] dout_cnt;
`endif

  binary_downscale_2x2 #(.IMG_W(W), .IMG_H(H), .THRESH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .din_sof    (din_sof),
    .cfg_thresh (cfg_thresh),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_sof   (dout_sof),
    .dout_eol   (dout_eol),
`ifdef RESIZE_CNT_OUT_EN
    .dout_cnt   (dout_cnt),
`endif
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the current frame as a 2D array plus the raster position.
  bit img[H][W];
  bit fr[H][W];
  int rp, cp, thr_m;
  int pulses, fds;
  bit last_valid, last_dout;
  bit seq_a[$];
  bit seq_b[$];
  bit rec_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rp = 0; cp = 0; thr_m = 2;
  endtask

  task automatic step(input bit v, input bit d, input bit s, input int cfg);
    logic [4:0] exp;
    int         cnt_e;
    exp = '0;
    cnt_e = 0;
    if (v) begin
      if (s) begin
        rp = 0; cp = 0; thr_m = cfg;
      end
      img[rp][cp] = d;
      if ((rp % 2 == 1) && (cp % 2 == 1)) begin
        cnt_e = int'(img[rp-1][cp-1]) + int'(img[rp-1][cp]) + int'(img[rp][cp-1])
              + int'(img[rp][cp]);
        exp = {1'b1, cnt_e >= thr_m, (rp == 1) && (cp == 1), cp == W - 1,
               (cp == W - 1) && (rp == H - 1)};
      end
      cp++;
      if (cp == W) begin
        cp = 0;
        rp++;
        if (rp == H) rp = 0;
      end
    end
    @(negedge clk);
    din_valid  = v;
    din        = v ? d : 1'($urandom);
    din_sof    = v ? s : 1'($urandom);
    cfg_thresh = v ? 3'(cfg) : 3'($urandom);
    @(posedge clk);
    #1;
    check("outputs", 32'({dout_valid, dout, dout_sof, dout_eol, frame_done}), 32'(exp));
`ifdef RESIZE_CNT_OUT_EN
    check("dout_cnt", 32'(dout_cnt), 32'(exp[4] ? cnt_e : 0));
`endif
    pulses += int'(dout_valid);
    fds += int'(frame_done);
    last_valid = dout_valid;
    last_dout = dout;
    if (dout_valid) begin
      if (rec_sel) seq_b.push_back(dout);
      else seq_a.push_back(dout);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input bit gaps, input bit use_sof, input int thr);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
        step(1'b1, fr[r][c], use_sof && (r == 0) && (c == 0), thr);
      end
    end
  endtask

  task automatic random_fr();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = 1'($urandom);
  endtask

  // p = {(0,0),(0,1),(1,0),(1,1)} of the single block under test.
  task automatic send_block(input logic [3:0] p, input int thr);
    step(1'b1, p[3], 1'b1, thr);
    step(1'b1, p[2], 1'b0, thr);
    for (int c = 2; c < W; c++) step(1'b1, 1'b0, 1'b0, thr);
    step(1'b1, p[1], 1'b0, thr);
    step(1'b1, p[0], 1'b0, thr);
  endtask

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; din_sof = 1'b0; cfg_thresh = 3'd0;
    rec_sel = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", 32'({dout_valid, dout, dout_sof, dout_eol, frame_done}), 32'd0);
    #11 rst_n = 1'b1;

    // All-ones frame at the reset threshold: 8 pulses, frame_done on the last only.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = 1'b1;
    pulses = 0; fds = 0;
    send_frame(1'b0, 1'b1, 2);
    check("ones_pulses", 32'(pulses), 32'd8);
    check("ones_frame_done", 32'(fds), 32'd1);

    // Single-block threshold rules.
    send_block(4'b1000, 1); check("blk_thr1", 32'({last_valid, last_dout}), 32'b11);
    send_block(4'b1000, 2); check("blk_thr2", 32'({last_valid, last_dout}), 32'b10);
    send_block(4'b1000, 4); check("blk_thr4", 32'({last_valid, last_dout}), 32'b10);
    send_block(4'b1111, 4); check("blk_and", 32'({last_valid, last_dout}), 32'b11);
    send_block(4'b1111, 5); check("blk_thr5", 32'({last_valid, last_dout}), 32'b10);
    send_block(4'b0000, 0); check("blk_thr0", 32'({last_valid, last_dout}), 32'b11);

    // Same random frame, continuous vs. gapped input, must give identical output.
    random_fr();
    seq_a.delete(); seq_b.delete();
    rec_sel = 1'b0;
    send_frame(1'b0, 1'b1, 2);
    rec_sel = 1'b1;
    send_frame(1'b1, 1'b1, 2);
    check("gap_len", 32'(seq_b.size()), 32'(seq_a.size()));
    for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
      check("gap_seq", 32'(seq_b[i]), 32'(seq_a[i]));

    // sof at pixel 13 aborts the frame; new threshold applies from there.
    random_fr();
    fds = 0;
    for (int i = 0; i < 13; i++) step(1'b1, fr[i / W][i % W], i == 0, 1);
    check("abort_no_done", 32'(fds), 32'd0);
    random_fr();
    send_frame(1'b0, 1'b1, 3);
    // Following frame without sof wraps to (0,0) by itself.
    for (int k = 0; k < 3; k++) begin
      random_fr();
      send_frame(1'b1, 1'b0, 0);
    end

    // Async reset right after an emitted 1, off the clock edge.
    step(1'b1, 1'b1, 1'b1, 1);
    for (int i = 1; i < W + 2; i++) step(1'b1, 1'b1, 1'b0, 1);
    check("pre_reset_dout", 32'({last_valid, last_dout}), 32'b11);
    #2 rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    check("async_reset_out", 32'({dout_valid, dout, dout_sof, dout_eol, frame_done}), 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      random_fr();
      send_frame(1'b1, k[0], $urandom_range(0, 7));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
